// File: rtl/tick_interval_meter.sv
// Measures the clock-cycle interval between successive 1-cycle ticks, flags
// out-of-tolerance periods, tracks lock and detects loss of ticks.
module tick_interval_meter #(
    parameter int unsigned M       = 10,
    parameter int unsigned TOL     = 0,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_in,
    input  logic         clear,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         err_tick,
    output logic         locked,
    output logic         timeout
);

    localparam int unsigned GW       = $clog2(LOCK_N + 1);
    localparam logic [W:0]  LO       = (W+1)'(M - TOL);
    localparam logic [W:0]  HI       = (W+1)'(M + TOL);
    localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);
    localparam logic [GW:0] LOCK_THR = (GW+1)'(LOCK_N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_TIMEOUT
    } state_t;

    state_t          state;
    logic [W-1:0]    cnt;
    logic [GW-1:0]   good_cnt;
    logic            in_tol_c;
    logic [GW:0]     good_inc_c;

    // Tolerance window check done one bit wider so M+TOL never wraps
    assign in_tol_c   = ({1'b0, cnt} >= LO) && ({1'b0, cnt} <= HI);
    assign good_inc_c = {1'b0, good_cnt} + (GW+1)'(1);

    always_ff @(posedge clk) begin
        period_valid <= 1'b0;
        err_tick     <= 1'b0;
        if (reset || clear) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            good_cnt <= '0;
            period   <= '0;
            locked   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (tick_in)
                cnt <= W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + W'(1);

            case (state)
                ST_IDLE: begin
                    if (tick_in)
                        state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (tick_in) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        if (in_tol_c) begin
                            good_cnt <= (good_inc_c >= LOCK_THR) ? GOOD_MAX : good_inc_c[GW-1:0];
                            if (good_inc_c >= LOCK_THR)
                                locked <= 1'b1;
                        end else begin
                            err_tick <= 1'b1;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        // TIMEOUT cycles have now elapsed since the last tick
                        state    <= ST_TIMEOUT;
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                ST_TIMEOUT: begin
                    if (tick_in) begin
                        state   <= ST_MEASURE;
                        timeout <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_interval_meter.sv
// Bench for tick_interval_meter: table of tick intervals with expected
// responses, checked through a scoreboard queue, plus timeout sequences.
module tb_tick_interval_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        tick0, tick1;
    logic [15:0] period0, period1;
    logic        pv0, pv1, err0, err1, lk0, lk1, to0, to1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int       dut;
        bit       rst;
        bit       clr;
        int       gap;
        bit       exp_pv;
        int       exp_period;
        bit       exp_err;
        bit       exp_locked;
        bit       exp_timeout;
    } vec_t;

    vec_t exp_q[$];
    vec_t tab[33];

    always #5 clk = ~clk;

    tick_interval_meter #(.M(10), .TOL(0), .LOCK_N(4), .TIMEOUT(40), .W(16)) dut0 (
        .clk(clk), .reset(reset), .tick_in(tick0), .clear(clear),
        .period(period0), .period_valid(pv0), .err_tick(err0),
        .locked(lk0), .timeout(to0)
    );

    tick_interval_meter #(.M(10), .TOL(1), .LOCK_N(4), .TIMEOUT(40), .W(16)) dut1 (
        .clk(clk), .reset(reset), .tick_in(tick1), .clear(clear),
        .period(period1), .period_valid(pv1), .err_tick(err1),
        .locked(lk1), .timeout(to1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int d, bit r, bit c, int g, bit pv, int per, bit er, bit lk, bit to);
        vec_t v;
        v.dut = d; v.rst = r; v.clr = c; v.gap = g;
        v.exp_pv = pv; v.exp_period = per; v.exp_err = er;
        v.exp_locked = lk; v.exp_timeout = to;
        return v;
    endfunction

    // Compare one DUT's outputs at the negedge after a sampled tick (or check quiet)
    task automatic mon_chk(input int d, input bit t, input logic pv, input logic [15:0] per,
                           input logic er, input logic lk, input logic to);
        vec_t v;
        if (t) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'(1), 32'(0));
            end else begin
                v = exp_q.pop_front();
                chk("tick_dut",    32'(d),   32'(v.dut));
                chk("period_valid", 32'(pv), 32'(v.exp_pv));
                chk("period",      32'(per), 32'(v.exp_period));
                chk("err_tick",    32'(er),  32'(v.exp_err));
                chk("locked",      32'(lk),  32'(v.exp_locked));
                chk("timeout",     32'(to),  32'(v.exp_timeout));
            end
        end else begin
            chk("quiet_period_valid", 32'(pv), 32'(0));
            chk("quiet_err_tick",     32'(er), 32'(0));
        end
    endtask

    initial begin : monitor
        bit t0, t1;
        forever begin
            @(posedge clk);
            t0 = tick0;
            t1 = tick1;
            @(negedge clk);
            mon_chk(0, t0, pv0, period0, err0, lk0, to0);
            mon_chk(1, t1, pv1, period1, err1, lk1, to1);
        end
    end

    task automatic send(input vec_t v);
        tick0 = 1'b0;
        tick1 = 1'b0;
        repeat (v.gap - 1) begin
            @(posedge clk);
            #1;
        end
        exp_q.push_back(v);
        if (v.dut == 0) tick0 = 1'b1; else tick1 = 1'b1;
        reset = v.rst;
        clear = v.clr;
        @(posedge clk);
        #1;
        tick0 = 1'b0;
        tick1 = 1'b0;
        reset = 1'b0;
        clear = 1'b0;
    endtask

    // Ticks stop after lock: timeout must rise exactly 40 edges after the last tick
    task automatic timeout_seq();
        repeat (38) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_timeout_level",  32'(to0), 32'(0));
        chk("pre_timeout_locked", 32'(lk0), 32'(1));
        @(posedge clk);
        @(negedge clk);
        chk("timeout_level",  32'(to0),     32'(1));
        chk("timeout_locked", 32'(lk0),     32'(0));
        chk("timeout_period", 32'(period0), 32'(10));
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("timeout_held", 32'(to0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // dut, rst, clr, gap, pv, period, err, locked, timeout
        tab[0]  = mk(0, 0, 0, 5,  0, 0,  0, 0, 0);
        tab[1]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[2]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[3]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[4]  = mk(0, 0, 0, 10, 1, 10, 0, 1, 0);
        tab[5]  = mk(0, 0, 0, 10, 1, 10, 0, 1, 0);
        tab[6]  = mk(0, 0, 0, 12, 1, 12, 1, 0, 0);
        tab[7]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[8]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[9]  = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[10] = mk(0, 0, 0, 10, 1, 10, 0, 1, 0);
        tab[11] = mk(0, 0, 0, 3,  0, 10, 0, 0, 0);
        tab[12] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[13] = mk(0, 0, 0, 40, 1, 40, 1, 0, 0);
        tab[14] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[15] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[16] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[17] = mk(0, 0, 0, 10, 1, 10, 0, 1, 0);
        tab[18] = mk(0, 0, 0, 1,  1, 1,  1, 0, 0);
        tab[19] = mk(0, 1, 0, 4,  0, 0,  0, 0, 0);
        tab[20] = mk(0, 0, 0, 6,  0, 0,  0, 0, 0);
        tab[21] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[22] = mk(0, 0, 1, 4,  0, 0,  0, 0, 0);
        tab[23] = mk(0, 0, 0, 3,  0, 0,  0, 0, 0);
        tab[24] = mk(0, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[25] = mk(1, 0, 0, 5,  0, 0,  0, 0, 0);
        tab[26] = mk(1, 0, 0, 9,  1, 9,  0, 0, 0);
        tab[27] = mk(1, 0, 0, 11, 1, 11, 0, 0, 0);
        tab[28] = mk(1, 0, 0, 10, 1, 10, 0, 0, 0);
        tab[29] = mk(1, 0, 0, 11, 1, 11, 0, 1, 0);
        tab[30] = mk(1, 0, 0, 8,  1, 8,  1, 0, 0);
        tab[31] = mk(1, 0, 0, 12, 1, 12, 1, 0, 0);
        tab[32] = mk(1, 0, 0, 11, 1, 11, 0, 0, 0);

        reset = 1'b1;
        clear = 1'b0;
        tick0 = 1'b0;
        tick1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_period0",  32'(period0), 32'(0));
        chk("rst_locked0",  32'(lk0),     32'(0));
        chk("rst_timeout0", 32'(to0),     32'(0));
        chk("rst_period1",  32'(period1), 32'(0));
        chk("rst_locked1",  32'(lk1),     32'(0));
        chk("rst_timeout1", 32'(to1),     32'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 33; i++) begin
            send(tab[i]);
            if (i == 10) timeout_seq();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
